// File: rtl/run_before_seq_enc_pkg.sv
// Shared types and constants for the CAVLC run_before encoder.
//   rb_state_e   : encoder sequencing states
//   MAX_CODE_LEN : longest run_before codeword (run_before=14 in escape range)
//   LEN_W        : width of a codeword length
//   ZL_ESCAPE    : zeros_left value from which the escape table applies
package cavlc_rb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    SHIFT,
    DONE
  } rb_state_e;

  localparam int unsigned MAX_CODE_LEN = 11;
  localparam int unsigned LEN_W        = 4;
  localparam int unsigned ZL_ESCAPE    = 7;

endpackage

// File: rtl/run_before_seq_enc_if.sv
// One-bit valid/ready code stream toward the bitstream FIFO.
//   out_valid : out_bit carries a code bit
//   out_bit   : current code bit, MSB-first
//   out_ready : sink accepts the bit this cycle
interface run_before_seq_enc_if;
  logic out_valid;
  logic out_bit;
  logic out_ready;

  modport master (output out_valid, output out_bit, input out_ready);
  modport slave  (input out_valid, input out_bit, output out_ready);
endinterface

// File: rtl/run_before_seq_enc_lut.sv
// Combinational run_before codeword table (also usable by the chroma DC path).
//   zl      : zeros_left, already capped at 7 (7 means "more than 6")
//   rb      : run_before value
//   code    : codeword, right-aligned
//   len     : codeword length in bits
//   illegal : no codeword exists for this (zl, rb) pair
module run_before_lut
  import cavlc_rb_pkg::*;
#(
  parameter int unsigned RB_W = 4
) (
  input  logic [2:0]              zl,
  input  logic [RB_W-1:0]         rb,
  output logic [MAX_CODE_LEN-1:0] code,
  output logic [LEN_W-1:0]        len,
  output logic                    illegal
);

  always_comb begin
    code    = '0;
    len     = '0;
    illegal = (zl == 3'd0) || (rb > RB_W'(14)) ||
              ((zl < 3'(ZL_ESCAPE)) && (rb > RB_W'(zl)));
    unique case (zl)
      3'd1: begin
        code = MAX_CODE_LEN'(~rb[0]);
        len  = LEN_W'(1);
      end
      3'd2: begin
        code = MAX_CODE_LEN'(rb[1:0] <= 2'd1);
        len  = (rb == '0) ? LEN_W'(1) : LEN_W'(2);
      end
      3'd3: begin
        code = MAX_CODE_LEN'(~rb[1:0]);
        len  = LEN_W'(2);
      end
      3'd4: begin
        code = (rb <= RB_W'(2)) ? MAX_CODE_LEN'(~rb[1:0]) : MAX_CODE_LEN'(rb == RB_W'(3));
        len  = (rb <= RB_W'(2)) ? LEN_W'(2) : LEN_W'(3);
      end
      3'd5: begin
        code = (rb <= RB_W'(1)) ? MAX_CODE_LEN'(~rb[1:0]) : MAX_CODE_LEN'(3'd5 - rb[2:0]);
        len  = (rb <= RB_W'(1)) ? LEN_W'(2) : LEN_W'(3);
      end
      3'd6: begin
        len = LEN_W'(3);
        unique case (rb[2:0])
          3'd0:    begin code = MAX_CODE_LEN'(3'b11); len = LEN_W'(2); end
          3'd1:    code = MAX_CODE_LEN'(3'b000);
          3'd2:    code = MAX_CODE_LEN'(3'b001);
          3'd3:    code = MAX_CODE_LEN'(3'b011);
          3'd4:    code = MAX_CODE_LEN'(3'b010);
          3'd5:    code = MAX_CODE_LEN'(3'b101);
          default: code = MAX_CODE_LEN'(3'b100);
        endcase
      end
      3'd7: begin
        // rb>=7: (rb-4) zeros then a one, i.e. value 1 in (rb-3) bits
        if (rb < RB_W'(7)) begin
          code = MAX_CODE_LEN'(~rb[2:0]);
          len  = LEN_W'(3);
        end else begin
          code = MAX_CODE_LEN'(1);
          len  = LEN_W'(rb - RB_W'(3));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/run_before_seq_enc.sv
// Block-level CAVLC run_before encoder: walks run_before values of one block,
// tracks zeros_left and streams each codeword MSB-first with backpressure.
//   clk, rst     : clock, asynchronous active-low reset
//   start        : block request, honoured only when idle
//   total_coeff  : nonzero coefficients in block
//   total_zeros  : zeros before the last nonzero coefficient
//   runs_flat    : run_before[i] at [i*RB_W +: RB_W]
//   bs           : code bit stream (valid/bit/ready)
//   busy         : block in progress
//   finish, err  : block-done pulse, with err when a run exceeds zeros_left
//   bit_count    : bits emitted for the block (saturating), held until next start
module run_before_seq_enc
  import cavlc_rb_pkg::*;
#(
  parameter int unsigned MAX_COEFF = 16,
  parameter int unsigned RB_W      = 4,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDX_W:0]            total_coeff,
  input  logic [RB_W-1:0]           total_zeros,
  input  logic [MAX_COEFF*RB_W-1:0] runs_flat,
  run_before_seq_enc_if.master      bs,
  output logic                      busy,
  output logic                      finish,
  output logic                      err,
  output logic [7:0]                bit_count
);

  rb_state_e                 state_q;
  logic [IDX_W:0]            tc_q;
  logic [MAX_COEFF*RB_W-1:0] runs_q;
  logic [RB_W-1:0]           zl_q;
  logic [IDX_W-1:0]          idx_q;
  logic [MAX_CODE_LEN-1:0]   sh_q;
  logic [LEN_W-1:0]          rem_q;
  logic                      flag_q;
  logic                      valid_q;
  logic                      busy_q;
  logic                      finish_q;
  logic                      err_q;
  logic [7:0]                cnt_q;

  logic [RB_W-1:0]         cur_rb;
  logic [2:0]              zl_cap;
  logic [MAX_CODE_LEN-1:0] lut_code;
  logic [LEN_W-1:0]        lut_len;
  logic                    lut_illegal;
  logic                    rb_bad;
  logic [RB_W-1:0]         zl_next;
  logic [IDX_W:0]          idx_inc;
  logic                    last_code;

  assign cur_rb    = runs_q[idx_q*RB_W +: RB_W];
  assign zl_cap    = (zl_q >= RB_W'(ZL_ESCAPE)) ? 3'(ZL_ESCAPE) : zl_q[2:0];
  assign rb_bad    = (cur_rb > zl_q) || lut_illegal;
  assign zl_next   = zl_q - cur_rb;
  assign idx_inc   = {1'b0, idx_q} + (IDX_W+1)'(1);
  // The last coefficient never carries a run_before code.
  assign last_code = (idx_inc == tc_q - (IDX_W+1)'(1));

  run_before_lut #(.RB_W(RB_W)) u_lut (
    .zl      (zl_cap),
    .rb      (cur_rb),
    .code    (lut_code),
    .len     (lut_len),
    .illegal (lut_illegal)
  );

  assign bs.out_valid = valid_q;
  assign bs.out_bit   = sh_q[MAX_CODE_LEN-1];
  assign busy         = busy_q;
  assign finish       = finish_q;
  assign err          = err_q;
  assign bit_count    = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tc_q     <= '0;
      runs_q   <= '0;
      zl_q     <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      rem_q    <= '0;
      flag_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            tc_q    <= total_coeff;
            runs_q  <= runs_flat;
            zl_q    <= total_zeros;
            idx_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ((total_coeff <= (IDX_W+1)'(1)) || (total_zeros == '0)) ? DONE : LOOKUP;
          end
        end
        LOOKUP: begin
          if (rb_bad) begin
            flag_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            // Left-align so the MSB of the remaining bits is always sh_q's top bit.
            sh_q    <= lut_code << (MAX_CODE_LEN - lut_len);
            rem_q   <= lut_len;
            valid_q <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (valid_q && bs.out_ready) begin
            sh_q  <= sh_q << 1;
            rem_q <= rem_q - LEN_W'(1);
            cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            if (rem_q == LEN_W'(1)) begin
              valid_q <= 1'b0;
              zl_q    <= zl_next;
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= (last_code || (zl_next == '0)) ? DONE : LOOKUP;
            end
          end
        end
        DONE: begin
          finish_q <= 1'b1;
          err_q    <= flag_q;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_before_seq_enc.sv
module tb_run_before_seq_enc;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  total_coeff;
  logic [3:0]  total_zeros;
  logic [63:0] runs_flat;
  logic        busy, finish, err;
  logic [7:0]  bit_count;

  run_before_seq_enc_if bs_if ();

  run_before_seq_enc #(.MAX_COEFF(16), .RB_W(4), .IDX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .total_coeff (total_coeff),
    .total_zeros (total_zeros),
    .runs_flat   (runs_flat),
    .bs          (bs_if),
    .busy        (busy),
    .finish      (finish),
    .err         (err),
    .bit_count   (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference results
  bit exp_bits[$];
  bit exp_err;
  // Observed results
  bit   got_bits[$];
  bit   got_fin;
  bit   got_err;
  bit   got_busy;
  int   got_cnt;
  int   stab_err;
  int   runs[16];

  // Codeword for a given zeros_left and run_before, straight from the table.
  function automatic string code_str(input int zl, input int rb);
    string z1[2] = '{"1", "0"};
    string z2[3] = '{"1", "01", "00"};
    string z3[4] = '{"11", "10", "01", "00"};
    string z4[5] = '{"11", "10", "01", "001", "000"};
    string z5[6] = '{"11", "10", "011", "010", "001", "000"};
    string z6[7] = '{"11", "000", "001", "011", "010", "101", "100"};
    string s;
    case (zl)
      1: return z1[rb];
      2: return z2[rb];
      3: return z3[rb];
      4: return z4[rb];
      5: return z5[rb];
      6: return z6[rb];
      default: begin
        if (rb < 7) return $sformatf("%03b", 7 - rb);
        s = "";
        for (int k = 0; k < rb - 4; k++) s = {s, "0"};
        return {s, "1"};
      end
    endcase
  endfunction

  task automatic build_expected(input int tc, input int tz);
    int zl;
    string s;
    exp_bits.delete();
    exp_err = 1'b0;
    zl = tz;
    for (int i = 0; i < tc - 1 && zl > 0; i++) begin
      if (runs[i] > zl) begin
        exp_err = 1'b1;
        break;
      end
      s = code_str(zl, runs[i]);
      for (int k = 0; k < s.len(); k++) exp_bits.push_back(s[k] == "1");
      zl -= runs[i];
    end
  endtask

  function automatic string q2s(input bit q[$]);
    string s = "";
    foreach (q[i]) s = {s, q[i] ? "1" : "0"};
    return s;
  endfunction

  function automatic bit same_bits();
    if (got_bits.size() != exp_bits.size()) return 1'b0;
    foreach (got_bits[i]) if (got_bits[i] != exp_bits[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Starts one block and records what the DUT emits; no checking here.
  task automatic drive_block(input int tc, input int tz, input bit rand_ready);
    bit prev_hold;
    bit prev_bit;
    bit rdy;
    @(posedge clk); #1;
    total_coeff = 5'(tc);
    total_zeros = 4'(tz);
    for (int i = 0; i < 16; i++) runs_flat[i*4 +: 4] = 4'(runs[i]);
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    got_busy = busy;
    got_bits.delete();
    got_fin   = 1'b0;
    got_err   = 1'b0;
    got_cnt   = -1;
    stab_err  = 0;
    prev_hold = 1'b0;
    prev_bit  = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (prev_hold && !(bs_if.out_valid === 1'b1 && bs_if.out_bit === prev_bit)) stab_err++;
      if (finish === 1'b1) begin
        got_fin = 1'b1;
        got_err = err;
        got_cnt = int'(bit_count);
        break;
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bs_if.out_ready = rdy;
      if (bs_if.out_valid === 1'b1 && rdy) got_bits.push_back(bs_if.out_bit);
      prev_hold = (bs_if.out_valid === 1'b1) && !rdy;
      prev_bit  = bs_if.out_bit;
      @(posedge clk); #1;
    end
    bs_if.out_ready = 1'b1;
  endtask

  task automatic set_runs(input int r0, input int r1, input int r2, input int r3);
    foreach (runs[i]) runs[i] = int'($urandom_range(0, 15));
    runs[0] = r0; runs[1] = r1; runs[2] = r2; runs[3] = r3;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bs_if.out_valid, bs_if.out_bit, busy, finish, err} !== 5'b0 || bit_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b b=%b busy=%b fin=%b err=%b cnt=%0d want all 0",
               bs_if.out_valid, bs_if.out_bit, busy, finish, err, bit_count);
    end
  endtask

  task automatic test_standard(input bit rand_ready, input string name);
    set_runs(1, 0, 0, 1);
    build_expected(5, 3);
    drive_block(5, 3, rand_ready);
    total++;
    if (!got_fin || !same_bits()) begin
      bad++;
      $display("FAIL %s_bits: got fin=%b bits=%s want bits=%s", name, got_fin, q2s(got_bits), q2s(exp_bits));
    end
    total++;
    if (got_cnt !== 6 || got_err !== 1'b0) begin
      bad++;
      $display("FAIL %s_count: got cnt=%0d err=%b want cnt=6 err=0", name, got_cnt, got_err);
    end
    total++;
    if (got_busy !== 1'b1 || stab_err != 0) begin
      bad++;
      $display("FAIL %s_busy_stable: got busy=%b unstable=%0d want busy=1 unstable=0", name, got_busy, stab_err);
    end
  endtask

  task automatic test_escape();
    set_runs(14, 0, 0, 0);
    build_expected(2, 14);
    drive_block(2, 14, 1'b0);
    total++;
    if (!got_fin || !same_bits() || q2s(exp_bits) != "00000000001") begin
      bad++;
      $display("FAIL escape_bits: got fin=%b bits=%s want 00000000001", got_fin, q2s(got_bits));
    end
    total++;
    if (got_cnt !== 11 || got_err !== 1'b0) begin
      bad++;
      $display("FAIL escape_count: got cnt=%0d err=%b want cnt=11 err=0", got_cnt, got_err);
    end
  endtask

  task automatic test_early_term();
    set_runs(2, 1, 1, 0);
    build_expected(4, 2);
    drive_block(4, 2, 1'b0);
    total++;
    if (!got_fin || !same_bits() || got_cnt !== 2) begin
      bad++;
      $display("FAIL early_term: got fin=%b bits=%s cnt=%0d want bits=00 cnt=2", got_fin, q2s(got_bits), got_cnt);
    end
  endtask

  task automatic test_degenerate_and_error();
    set_runs(3, 3, 3, 3);
    drive_block(1, 5, 1'b0);
    total++;
    if (!got_fin || got_bits.size() != 0 || got_cnt !== 0 || got_err !== 1'b0) begin
      bad++;
      $display("FAIL degenerate_tc1: got fin=%b nbits=%0d cnt=%0d err=%b want fin=1 nbits=0 cnt=0 err=0",
               got_fin, got_bits.size(), got_cnt, got_err);
    end
    set_runs(2, 0, 0, 0);
    drive_block(3, 1, 1'b0);
    total++;
    if (!got_fin || got_bits.size() != 0 || got_cnt !== 0 || got_err !== 1'b1) begin
      bad++;
      $display("FAIL run_gt_zl: got fin=%b nbits=%0d cnt=%0d err=%b want fin=1 nbits=0 cnt=0 err=1",
               got_fin, got_bits.size(), got_cnt, got_err);
    end
    @(posedge clk); #1;
    total++;
    if (finish !== 1'b0 || err !== 1'b0 || bit_count !== 8'd0) begin
      bad++;
      $display("FAIL finish_pulse_width: got fin=%b err=%b cnt=%0d want 0 0 0", finish, err, bit_count);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit saw_fin;
    @(posedge clk); #1;
    total_coeff = 5'd2;
    total_zeros = 4'd14;
    runs_flat   = '0;
    runs_flat[3:0] = 4'd14;
    bs_if.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bs_if.out_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_shift_active: got v=%b busy=%b want 1 1", bs_if.out_valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bs_if.out_valid, bs_if.out_bit, busy, finish, err} !== 5'b0 || bit_count !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got v=%b b=%b busy=%b fin=%b err=%b cnt=%0d want all 0",
               bs_if.out_valid, bs_if.out_bit, busy, finish, err, bit_count);
    end
    @(posedge clk); #1 rst = 1'b1;
    saw_fin = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (finish === 1'b1 || bs_if.out_valid === 1'b1) saw_fin = 1'b1;
    end
    total++;
    if (saw_fin !== 1'b0) begin
      bad++;
      $display("FAIL aborted_block_activity: got activity=%b want 0", saw_fin);
    end
    test_standard(1'b0, "after_reset");
  endtask

  task automatic test_random();
    int tc, tz, zl;
    for (int n = 0; n < 40; n++) begin
      tc = int'($urandom_range(0, 16));
      tz = int'($urandom_range(0, (tc >= 2) ? 16 - tc : 15));
      zl = tz;
      foreach (runs[i]) begin
        if ($urandom_range(0, 11) == 0 && zl < 15) runs[i] = zl + 1;
        else runs[i] = int'($urandom_range(0, zl));
        if (runs[i] <= zl) zl -= runs[i];
      end
      build_expected(tc, tz);
      drive_block(tc, tz, 1'b1);
      total++;
      if (!got_fin || !same_bits() || got_cnt != exp_bits.size() || got_err !== exp_err || stab_err != 0) begin
        bad++;
        $display("FAIL random_%0d tc=%0d tz=%0d: got fin=%b bits=%s cnt=%0d err=%b unstable=%0d want bits=%s cnt=%0d err=%b",
                 n, tc, tz, got_fin, q2s(got_bits), got_cnt, got_err, stab_err,
                 q2s(exp_bits), exp_bits.size(), exp_err);
      end
    end
  endtask

  initial begin
    start = 1'b0;
    total_coeff = '0;
    total_zeros = '0;
    runs_flat = '0;
    bs_if.out_ready = 1'b1;
    test_reset();
    test_standard(1'b0, "standard");
    test_escape();
    test_early_term();
    test_standard(1'b1, "backpressure");
    test_degenerate_and_error();
    test_reset_mid_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/run_before_seq_enc.md
Name: run_before_seq_enc

Overview:
- Block-level run_before encoder for H.264 CAVLC. It walks all run_before values of one 4x4 (or smaller) block in reverse scan order and tracks zeros_left internally.
- It looks up each codeword per the standard run_before table, including the zerosLeft>6 escape range up to run_before=14.
- Codewords are serialised MSB-first onto a one-bit valid/ready stream feeding the bitstream FIFO.
- Sits after the total_zeros stage in the CAVLC encoder chain and handles all coefficients of a block per start, with backpressure.

Parameters:
- MAX_COEFF, 16, maximum coefficients per block (4 for chroma DC); sets run array depth and index width.
- RB_W, 4, width of each run_before entry and of zeros_left.
- IDX_W, 4, width of coefficient index (clog2(MAX_COEFF)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- total_coeff  in  IDX_W+1  nonzero coefficients in block (0..MAX_COEFF).
- total_zeros  in  RB_W  zeros before last nonzero coefficient.
- runs_flat  in  MAX_COEFF*RB_W  run_before[i] at bits [i*RB_W +: RB_W]; i=0 is highest-frequency nonzero coefficient.
- out_valid  out  1  out_bit is valid.
- out_bit  out  1  current code bit, MSB-first.
- out_ready  in  1  FIFO accepts bit (not full).
- busy  out  1  high from the cycle after an accepted start until finish.
- finish  out  1  one-cycle pulse, block done.
- err  out  1  one-cycle pulse with finish when run_before[i] > zeros_left.
- bit_count  out  8  bits emitted for current block; valid at finish, held until next start.

Behaviour:
- Reset: state IDLE. out_valid, out_bit, busy, finish, err = 0. bit_count = 0. Internal regs cleared. Reset mid-block aborts immediately; no finish.
- start in IDLE: capture total_coeff, total_zeros, runs_flat; zl <= total_zeros, idx <= 0, bit_count <= 0. start while busy is ignored.
- IDLE -> LOOKUP, or -> DONE if total_coeff <= 1 or total_zeros == 0.
- LOOKUP (1 cycle):
  - lut(min(zl,7), run[idx]) -> code[10:0], len[3:0]. Load shift reg and bit counter.
  - If run[idx] > zl: err flagged, no bits, go to DONE.
- SHIFT:
  - out_valid=1, out_bit = code MSB of the remaining len bits.
  - A bit transfers on out_valid && out_ready; then shift, bit_count++.
  - While !out_ready, out_bit is held stable.
  - After last bit: zl <= zl - run[idx], idx++.
  - If idx+1 == total_coeff-1 or new zl == 0 -> DONE, else -> LOOKUP.
- DONE: finish=1 (err=1 if flagged) for one cycle, busy=0 next, -> IDLE.
- The last (lowest-frequency) coefficient never gets a code. runs_flat beyond the processed index is don't-care.
- Code table (zl: rb0..):
  - zl1: 1, 0
  - zl2: 1, 01, 00
  - zl3: 11, 10, 01, 00
  - zl4: 11, 10, 01, 001, 000
  - zl5: 11, 10, 011, 010, 001, 000
  - zl6: 11, 000, 001, 011, 010, 101, 100
  - zl>6: 111, 110, 101, 100, 011, 010, 001, then rb>=7 is (rb-4) zeros followed by 1 (rb14 = 11 bits).
- Throughput: one bit per cycle when ready, plus one LOOKUP cycle per code.
- bit_count saturates at 255. Maximum legal block output is far below this.

Decomposition:
- Package cavlc_rb_pkg: state enum (IDLE, LOOKUP, SHIFT, DONE), MAX_CODE_LEN=11, LEN_W=4, ZL_ESCAPE=7.
- Sub-module run_before_lut (combinational): inputs zl (capped 3 bits) and rb (RB_W); outputs code[10:0] right-aligned, len[3:0], illegal. It is reusable by the chroma DC path.

Test Plan:
- Standard example: tc=5, tz=3, runs[0..3]=1,0,0,1 -> bits 1,0,1,1,0,1; bit_count=6; finish, err=0.
- Escape max: tc=2, tz=14, runs[0]=14 -> ten 0s then 1; bit_count=11.
- Early termination: tc=4, tz=2, runs[0]=2 -> bits 0,0; finish after 2 bits, runs[1..] ignored.
- Backpressure: previous standard case with out_ready toggled 1/0 randomly -> identical bit sequence; out_bit stable while !ready; no bit lost or duplicated.
- Degenerate and error:
  - tc=1, tz=5 -> finish with no bits, bit_count=0.
  - tc=3, tz=1, runs[0]=2 -> err and finish together, 0 bits.
- Reset mid-SHIFT of the escape case -> all outputs 0 next edge, state IDLE; a new start then encodes correctly.
